// File: rtl/matrix_scanner.sv
// matrix_scanner: column-scan sequencer for a 5x7 LED matrix.
// Steps through five physical columns. Each column dwells DWELL cycles: the
// first BLANK cycles have the strobe off (anti-ghosting), and the rest drive
// it. Frame data is double-buffered: loads land in a shadow buffer and move to
// the active registers only when the scan enters column 0.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   enable                  scan enable; low returns to IDLE
//   load, data_2/1/0        shadow-buffer write strobe and row data (bit 6 = row 0)
//   col_2/1/0               active frame data for the row multiplexer
//   ring_counter            one-hot group select (100/010/001/010/100 per column)
//   col_en                  one-hot physical column strobe
//   load_ack                pulse one cycle after a sampled load
//   frame_done              pulse on the first BLANK cycle after column 4
module matrix_scanner #(
    parameter int unsigned DWELL = 1000,
    parameter int unsigned BLANK = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       load,
    input  logic [6:0] data_2,
    input  logic [6:0] data_1,
    input  logic [6:0] data_0,
    output logic [6:0] col_2,
    output logic [6:0] col_1,
    output logic [6:0] col_0,
    output logic [2:0] ring_counter,
    output logic [4:0] col_en,
    output logic       load_ack,
    output logic       frame_done
);

    localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned N_COL = 5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_DRIVE
    } state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               swap_nxt;
    logic               wrap_nxt;
    logic [2:0]         ring_nxt;
    logic [N_COL-1:0]   col_en_nxt;
    logic [6:0]         shadow_2, shadow_1, shadow_0;
    logic               pending;

    // State register plus all registered outputs and frame buffers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            idx          <= '0;
            cnt          <= '0;
            ring_counter <= '0;
            col_en       <= '0;
            frame_done   <= 1'b0;
            load_ack     <= 1'b0;
            shadow_2     <= '0;
            shadow_1     <= '0;
            shadow_0     <= '0;
            pending      <= 1'b0;
            col_2        <= '0;
            col_1        <= '0;
            col_0        <= '0;
        end else begin
            state        <= state_nxt;
            idx          <= idx_nxt;
            cnt          <= cnt_nxt;
            ring_counter <= ring_nxt;
            col_en       <= col_en_nxt;
            frame_done   <= wrap_nxt;
            load_ack     <= load;
            // Swap reads the pre-edge shadow; a coincident load refills it
            // and keeps pending set for the following frame.
            if (swap_nxt && pending) begin
                col_2 <= shadow_2;
                col_1 <= shadow_1;
                col_0 <= shadow_0;
            end
            if (load) begin
                shadow_2 <= data_2;
                shadow_1 <= data_1;
                shadow_0 <= data_0;
                pending  <= 1'b1;
            end else if (swap_nxt) begin
                pending  <= 1'b0;
            end
        end
    end

    // Next-state: column sequencing and dwell counting.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        swap_nxt  = 1'b0;
        wrap_nxt  = 1'b0;
        if (!enable) begin
            state_nxt = S_IDLE;
            idx_nxt   = '0;
            cnt_nxt   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state_nxt = S_BLANK;
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                    swap_nxt  = 1'b1;
                end
                S_BLANK: begin
                    cnt_nxt = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(BLANK - 1)) begin
                        state_nxt = S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    if (cnt == CNT_W'(DWELL - 1)) begin
                        state_nxt = S_BLANK;
                        cnt_nxt   = '0;
                        if (idx == IDX_W'(N_COL - 1)) begin
                            idx_nxt  = '0;
                            swap_nxt = 1'b1;
                            wrap_nxt = 1'b1;
                        end else begin
                            idx_nxt = idx + IDX_W'(1);
                        end
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Output decode from the next state so the outputs can be registered.
    always_comb begin
        ring_nxt   = '0;
        col_en_nxt = '0;
        if (state_nxt != S_IDLE) begin
            case (idx_nxt)
                IDX_W'(0), IDX_W'(4): ring_nxt = 3'b100;
                IDX_W'(1), IDX_W'(3): ring_nxt = 3'b010;
                IDX_W'(2):            ring_nxt = 3'b001;
                default:              ring_nxt = 3'b000;
            endcase
        end
        if (state_nxt == S_DRIVE) begin
            col_en_nxt = N_COL'(1) << idx_nxt;
        end
    end

endmodule

// File: tb/tb_matrix_scanner.sv
// Bench for matrix_scanner with DWELL=8, BLANK=2. A time-based frame model
// predicts every output each cycle; directed literal checks pin the model.
module tb_matrix_scanner;

    localparam int unsigned DWELL = 8;
    localparam int unsigned BLANK = 2;
    localparam int          FRAME = 5 * DWELL;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       load;
    logic [6:0] data_2, data_1, data_0;
    logic [6:0] col_2, col_1, col_0;
    logic [2:0] ring_counter;
    logic [4:0] col_en;
    logic       load_ack;
    logic       frame_done;

    matrix_scanner #(.DWELL(DWELL), .BLANK(BLANK)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .load         (load),
        .data_2       (data_2),
        .data_1       (data_1),
        .data_0       (data_0),
        .col_2        (col_2),
        .col_1        (col_1),
        .col_0        (col_0),
        .ring_counter (ring_counter),
        .col_en       (col_en),
        .load_ack     (load_ack),
        .frame_done   (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: time since the scan started, plus shadow/active frame data.
    bit         m_run;
    int         m_t;
    logic [6:0] m_sh [3];
    logic [6:0] m_act [3];
    bit         m_pend;
    bit         m_ack;
    bit         m_fd;
    bit         m_entry;
    int         m_pos;
    int         m_idx;
    logic [2:0] e_ring;
    logic [4:0] e_colen;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_run = 0; m_t = 0; m_pend = 0; m_ack = 0; m_fd = 0;
            for (int i = 0; i < 3; i++) begin
                m_sh[i] = '0;
                m_act[i] = '0;
            end
        end else begin
            m_entry = 0;
            m_fd = 0;
            if (!enable) begin
                m_run = 0;
            end else if (!m_run) begin
                m_run = 1; m_t = 0; m_entry = 1;
            end else begin
                m_t++;
                if (m_t % FRAME == 0) begin
                    m_entry = 1;
                    m_fd = 1;
                end
            end
            if (m_entry && m_pend) begin
                for (int i = 0; i < 3; i++) m_act[i] = m_sh[i];
                m_pend = 0;
            end
            if (load) begin
                m_sh[0] = data_0; m_sh[1] = data_1; m_sh[2] = data_2;
                m_pend = 1;
            end
            m_ack = load;
        end
        e_ring = '0;
        e_colen = '0;
        if (m_run) begin
            m_pos = m_t % FRAME;
            m_idx = m_pos / DWELL;
            e_ring = (m_idx == 0 || m_idx == 4) ? 3'b100 : (m_idx == 2 ? 3'b001 : 3'b010);
            if ((m_pos % DWELL) >= BLANK) e_colen = 5'(1 << m_idx);
        end
        #1;
        chk("model_ring", 32'(ring_counter), 32'(e_ring));
        chk("model_col_en", 32'(col_en), 32'(e_colen));
        chk("model_frame_done", 32'(frame_done), 32'(m_fd));
        chk("model_load_ack", 32'(load_ack), 32'(m_ack));
        chk("model_col_2", 32'(col_2), 32'(m_act[2]));
        chk("model_col_1", 32'(col_1), 32'(m_act[1]));
        chk("model_col_0", 32'(col_0), 32'(m_act[0]));
    end

    // cur = index of the cycle whose negedge we are at; cycle 0 follows the
    // first edge that samples enable high.
    int cur;
    task automatic go_to(input int k);
        while (cur < k) begin
            @(negedge clk);
            cur++;
        end
    endtask

    task automatic do_load(input logic [6:0] a, input logic [6:0] b, input logic [6:0] c);
        load = 1'b1; data_2 = a; data_1 = b; data_0 = c;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; load = 1'b0;
        data_2 = '0; data_1 = '0; data_0 = '0;
        repeat (3) @(negedge clk);
        chk("rst_col_en", 32'(col_en), 32'h0);
        chk("rst_ring", 32'(ring_counter), 32'h0);
        chk("rst_col_2", 32'(col_2), 32'h0);
        chk("rst_frame_done", 32'(frame_done), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        enable = 1'b1; cur = -1;

        // Frame 1: sequence and first load.
        go_to(0);  chk("c0_ring", 32'(ring_counter), 32'b100);
                   chk("c0_col_en", 32'(col_en), 32'h0);
        go_to(1);  chk("c1_col_en", 32'(col_en), 32'h0);
        go_to(2);  chk("c2_col_en", 32'(col_en), 32'b00001);
        go_to(5);  do_load(7'h41, 7'h22, 7'h14);
        go_to(6);  load = 1'b0;
                   chk("c6_load_ack", 32'(load_ack), 32'h1);
        go_to(7);  chk("c7_col_en", 32'(col_en), 32'b00001);
        go_to(8);  chk("c8_col_en", 32'(col_en), 32'h0);
                   chk("c8_ring", 32'(ring_counter), 32'b010);
        go_to(10); chk("c10_col_en", 32'(col_en), 32'b00010);
        go_to(16); chk("c16_ring", 32'(ring_counter), 32'b001);
        go_to(39); chk("c39_col_en", 32'(col_en), 32'b10000);
                   chk("c39_col_2", 32'(col_2), 32'h0);
                   chk("c39_frame_done", 32'(frame_done), 32'h0);
        go_to(40); chk("c40_frame_done", 32'(frame_done), 32'h1);
                   chk("c40_col_2", 32'(col_2), 32'h41);
                   chk("c40_col_1", 32'(col_1), 32'h22);
                   chk("c40_col_0", 32'(col_0), 32'h14);
        go_to(41); chk("c41_frame_done", 32'(frame_done), 32'h0);

        // Frame 2: last load wins.
        go_to(45); do_load(7'h01, 7'h00, 7'h00);
        go_to(46); load = 1'b0;
        go_to(50); do_load(7'h7F, 7'h00, 7'h00);
        go_to(51); load = 1'b0;
        go_to(79); chk("c79_col_2", 32'(col_2), 32'h41);
        go_to(80); chk("c80_col_2", 32'(col_2), 32'h7F);
                   chk("c80_frame_done", 32'(frame_done), 32'h1);

        // Frame 3: load sampled on the wrap edge.
        go_to(90);  do_load(7'h2A, 7'h00, 7'h00);
        go_to(91);  load = 1'b0;
        go_to(119); do_load(7'h55, 7'h00, 7'h00);
        go_to(120); load = 1'b0;
                    chk("c120_col_2", 32'(col_2), 32'h2A);
                    chk("c120_load_ack", 32'(load_ack), 32'h1);
        go_to(159); chk("c159_col_2", 32'(col_2), 32'h2A);
        go_to(160); chk("c160_col_2", 32'(col_2), 32'h55);

        // Disable in idx 1 DRIVE, load while idle, re-enable.
        go_to(173); chk("c173_col_en", 32'(col_en), 32'b00010);
                    enable = 1'b0;
        go_to(174); chk("dis_col_en", 32'(col_en), 32'h0);
                    chk("dis_ring", 32'(ring_counter), 32'h0);
                    chk("dis_frame_done", 32'(frame_done), 32'h0);
        go_to(176); do_load(7'h11, 7'h22, 7'h33);
        go_to(177); load = 1'b0;
        go_to(180); chk("idle_col_2", 32'(col_2), 32'h55);
                    enable = 1'b1; cur = -1;
        go_to(0);   chk("re_col_2", 32'(col_2), 32'h11);
                    chk("re_col_0", 32'(col_0), 32'h33);
                    chk("re_ring", 32'(ring_counter), 32'b100);
                    chk("re_frame_done", 32'(frame_done), 32'h0);
        go_to(2);   chk("re_col_en", 32'(col_en), 32'b00001);

        // Asynchronous reset mid-DRIVE with a pending load.
        go_to(20); do_load(7'h66, 7'h00, 7'h00);
        go_to(21); load = 1'b0;
                   chk("pre_rst_col_en", 32'(col_en), 32'b00100);
                   rst_n = 1'b0;
                   #1;
                   chk("arst_col_en", 32'(col_en), 32'h0);
                   chk("arst_ring", 32'(ring_counter), 32'h0);
                   chk("arst_load_ack", 32'(load_ack), 32'h0);
                   chk("arst_col_2", 32'(col_2), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1; cur = -1;
        go_to(0);  chk("post_rst_ring", 32'(ring_counter), 32'b100);
                   chk("post_rst_col_2", 32'(col_2), 32'h0);
        go_to(40); chk("post_rst_frame_done", 32'(frame_done), 32'h1);
                   chk("post_rst_col_2_f2", 32'(col_2), 32'h0);
        go_to(42);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/matrix_scanner.md
# matrix_scanner

Column-scan sequencer for the 5×7 LED matrix; it sources the `ring_counter` select and the three row-data groups that the row multiplexer consumes. It drives the five physical column strobes in sequence. Each column gets a fixed dwell time, and each dwell starts with a blanking interval to suppress ghosting. Frame data arrives through a double-buffered load handshake, and the new frame is applied only at a frame boundary.

## Interface
- `DWELL`, 1000: clock cycles per column (blank + drive); legal range ≥ 2.
- `BLANK`, 16: blanking cycles at the start of each column; legal range 1 ≤ BLANK < DWELL.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `enable` in 1: scan enable; low forces IDLE.
- `load` in 1: one-cycle strobe; captures `data_2/1/0` into the shadow buffer.
- `data_2` in 7: shadow data for columns 0 & 4; bit 6 = row 0.
- `data_1` in 7: shadow data for columns 1 & 3.
- `data_0` in 7: shadow data for column 2.
- `col_2`, `col_1`, `col_0` out 7 each: active frame data, registered, to the row multiplexer.
- `ring_counter` out 3: one-hot group select. Bit 2 selects `col_2`, bit 1 `col_1`, bit 0 `col_0`. It is 000 in IDLE.
- `col_en` out 5: one-hot physical column strobe, active-high; bit n = column n.
- `load_ack` out 1: one-cycle pulse, the cycle after `load` is sampled.
- `frame_done` out 1: one-cycle pulse when column 4 completes and the scan wraps.

## Operation
- States:
  - IDLE: outputs blank.
  - BLANK: `ring_counter` valid, `col_en`=0.
  - DRIVE: `ring_counter` valid, `col_en` one-hot.
- Column index `idx` runs 0..4 and maps to `ring_counter` as follows:
  - 0 → 100
  - 1 → 010
  - 2 → 001
  - 3 → 010
  - 4 → 100
- DRIVE asserts `col_en[idx]`.
- Dwell counter `cnt` has width $clog2(DWELL). It resets to 0 on entry to each column and increments every cycle in BLANK/DRIVE.
- State transitions:
  - IDLE → BLANK (idx=0, cnt=0) on the edge where `enable`=1.
  - BLANK → DRIVE when cnt == BLANK-1.
  - DRIVE with cnt == DWELL-1 and idx<4: go to BLANK, idx+1, cnt=0.
  - DRIVE with cnt == DWELL-1 and idx==4: go to BLANK, idx=0, cnt=0, and assert `frame_done` in the following cycle.
  - Any state with `enable`=0 → IDLE at the next edge; idx and cnt clear; `col_en`=0, `ring_counter`=000. There is no frame completion in this case.
- Shadow buffer:
  - `load`=1 writes `data_*` into shadow and sets `pending`, regardless of state.
  - A repeated `load` while pending overwrites the shadow; the last load wins.
- Swap:
  - On every entry to idx 0 BLANK (from IDLE or from the wrap), if `pending`=1, shadow is copied to `col_2/1/0` and `pending` clears.
  - Active data never changes mid-frame.
- Simultaneous `load` and swap on the same edge:
  - The swap uses the shadow contents from before the edge.
  - The new data lands in shadow and `pending` stays 1.
- Reset values: state IDLE, idx 0, cnt 0, `ring_counter` 000, `col_en` 00000, `col_2/1/0` 0, shadow 0, `pending` 0, `load_ack` 0, `frame_done` 0.
- Reset mid-frame aborts immediately (asynchronous); no `frame_done`.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `enable` sampled high at edge E: BLANK for idx 0 is visible after E. `col_en[0]` rises BLANK cycles after E.
- Per column: `col_en` is low for BLANK cycles, then high for DWELL-BLANK cycles. Consecutive strobes are separated by exactly BLANK low cycles.
- Full frame: 5×DWELL cycles. `frame_done` pulses once per frame, coincident with the first BLANK cycle of the next frame.
- `load_ack` latency: 1 cycle after `load`.
- Shadow-to-display latency: from the acknowledged load to the next idx-0 entry, at most 5×DWELL cycles.
- `ring_counter` changes only on column boundaries. It is stable across all BLANK and DRIVE cycles of a column.

## Test plan
All scenarios use DWELL=8, BLANK=2.
- Reset then `enable`=1 → `col_en` sequence 00000×2, 00001×6, 00000×2, 00010×6 … 10000×6. `ring_counter` sequence 100,010,001,010,100. `frame_done` pulses at cycle 40, then every 40 cycles.
- `load` with data_2=7'h41, data_1=7'h22, data_0=7'h14 at cycle 5 → `load_ack` at cycle 6. `col_*` stay 0 until the wrap at cycle 40, then equal 41/22/14.
- Two loads in one frame (7'h01, then 7'h7F on data_2) → only 7'h7F appears at the next idx-0 entry.
- `load` on the exact wrap edge → the old shadow is applied and the new data applies one frame later.
- `enable` dropped at cycle 13 (idx 1 DRIVE) → IDLE next cycle with all-zero outputs, no `frame_done`. Re-enable restarts at idx 0 BLANK.
- `rst_n` asserted mid-DRIVE, between clock edges → outputs go to reset values immediately, without waiting for a clock edge. Pending shadow is discarded.
